// File: rtl/md_pkg.sv
// Shared encodings and op-class predicates for the iterative multiply/divide unit.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_MADD  = 3'd2;
    localparam logic [2:0] MD_MADDU = 3'd3;
    localparam logic [2:0] MD_MSUB  = 3'd4;
    localparam logic [2:0] MD_MSUBU = 3'd5;
    localparam logic [2:0] MD_DIV   = 3'd6;
    localparam logic [2:0] MD_DIVU  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    function automatic logic is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MADD) || (op == MD_MSUB) || (op == MD_DIV);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_acc(input logic [2:0] op);
        return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
    endfunction

endpackage

// File: rtl/md_divstep.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module md_divstep #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {2'b00, div_i};
    assign q_o     = (shifted >= {2'b00, div_i});
    assign rem_o   = q_o ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/md_unit.sv
// Iterative multiply / multiply-accumulate / divide unit returning {HI,LO}.
// Magnitudes are iterated unsigned; signs are reapplied in the FIX state.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [2:0]           op_i,
    input  logic [WIDTH-1:0]     opa_i,
    input  logic [WIDTH-1:0]     opb_i,
    input  logic [WIDTH-1:0]     hi_i,
    input  logic [WIDTH-1:0]     lo_i,
    input  logic                 annul_i,
    output logic                 busy_o,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 div_by_zero_o
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned DW = 2 * WIDTH;

    md_state_e        state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [DW-1:0]    hilo_q, hilo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, ready_q, ready_d, dbz_q, dbz_d;
    logic [DW-1:0]    result_q, result_d;

    logic             sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_next;
    logic             q_bit;
    logic [DW-1:0]    prod, fix_res;
    logic [WIDTH-1:0] quo, rmd;

    md_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem_i (rem_q),
        .bit_i (acc_q[WIDTH-1]),
        .div_i (opd_q),
        .rem_o (rem_next),
        .q_o   (q_bit)
    );

    // Operand sign/magnitude split at accept, shift-add step, and sign fix-up.
    always_comb begin
        sa      = is_signed(op_i) && opa_i[WIDTH-1];
        sb      = is_signed(op_i) && opb_i[WIDTH-1];
        mag_a   = sa ? (WIDTH'(0) - opa_i) : opa_i;
        mag_b   = sb ? (WIDTH'(0) - opb_i) : opb_i;
        mul_sum = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        prod    = (is_signed(op_q) && (neg_a_q ^ neg_b_q)) ? (DW'(0) - acc_q) : acc_q;
        quo     = (is_signed(op_q) && (neg_a_q ^ neg_b_q)) ? (WIDTH'(0) - acc_q[WIDTH-1:0])
                                                           : acc_q[WIDTH-1:0];
        rmd     = (is_signed(op_q) && neg_a_q) ? (WIDTH'(0) - rem_q[WIDTH-1:0])
                                               : rem_q[WIDTH-1:0];
        if (is_div(op_q))
            fix_res = {rmd, quo};
        else if (is_acc(op_q))
            fix_res = ((op_q == MD_MSUB) || (op_q == MD_MSUBU)) ? (hilo_q - prod) : (hilo_q + prod);
        else
            fix_res = prod;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        opd_d   = opd_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        hilo_d  = hilo_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !annul_i) begin
                    op_d    = op_i;
                    neg_a_d = sa;
                    neg_b_d = sb;
                    hilo_d  = {hi_i, lo_i};
                    cnt_d   = '0;
                    rem_d   = '0;
                    if (is_div(op_i)) begin
                        opd_d = mag_b;
                        acc_d = {{WIDTH{1'b0}}, mag_a};
                    end else begin
                        opd_d = mag_a;
                        acc_d = {{WIDTH{1'b0}}, mag_b};
                    end
                    state_d = (is_div(op_i) && (opb_i == '0)) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (is_div(op_q)) begin
                    acc_d = {acc_q[DW-1:WIDTH], acc_q[WIDTH-2:0], q_bit};
                    rem_d = rem_next;
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(WIDTH - 1))
                    state_d = ST_FIX;
            end
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: if (!start_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (annul_i && (state_q != ST_IDLE))
            state_d = ST_IDLE;

        busy_d  = (state_d == ST_CALC) || (state_d == ST_FIX);
        ready_d = (state_d == ST_DONE);
        // Entering DONE straight from IDLE only happens for a zero divisor.
        if (state_d != ST_DONE) begin
            result_d = '0;
            dbz_d    = 1'b0;
        end else if (state_q == ST_FIX) begin
            result_d = fix_res;
            dbz_d    = 1'b0;
        end else if (state_q == ST_IDLE) begin
            result_d = '0;
            dbz_d    = 1'b1;
        end else begin
            result_d = result_q;
            dbz_d    = dbz_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            opd_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            hilo_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            opd_q    <= opd_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            hilo_q   <= hilo_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            dbz_q    <= dbz_d;
            result_q <= result_d;
        end
    end

    assign busy_o        = busy_q;
    assign ready_o       = ready_q;
    assign result_o      = result_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit at WIDTH=32 and WIDTH=8 with hand-computed results.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, annul;
    logic [2:0]  op;
    logic [31:0] opa, opb, hi, lo;
    logic        busy, ready, dbz;
    logic [63:0] result;

    logic        start8;
    logic [2:0]  op8;
    logic [7:0]  opa8, opb8;
    logic        busy8, ready8, dbz8;
    logic [15:0] result8;

    int total = 0;
    int bad   = 0;
    int lat;
    int busy_err;
    int seen_ready;

    always #5 clk = ~clk;

    md_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start_i(start), .op_i(op), .opa_i(opa), .opb_i(opb),
        .hi_i(hi), .lo_i(lo), .annul_i(annul), .busy_o(busy), .ready_o(ready),
        .result_o(result), .div_by_zero_o(dbz)
    );

    md_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .op_i(op8), .opa_i(opa8), .opb_i(opb8),
        .hi_i(8'h00), .lo_i(8'h00), .annul_i(1'b0), .busy_o(busy8), .ready_o(ready8),
        .result_o(result8), .div_by_zero_o(dbz8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts an op on the next edge and counts cycles until ready_o; busy_o is tracked meanwhile.
    task automatic run32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l);
        op = o; opa = a; opb = b; hi = h; lo = l; start = 1'b1;
        lat = 0;
        busy_err = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ready) break;
            if (!busy) busy_err++;
        end
    endtask

    task automatic release32(input string tag);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_idle_ready"}, 64'(ready), 64'd0);
        check({tag, "_idle_result"}, result, 64'd0);
    endtask

    task automatic run8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        op8 = o; opa8 = a; opb8 = b; start8 = 1'b1;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ready8) break;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; annul = 1'b0; op = 3'd0;
        opa = '0; opb = '0; hi = '0; lo = '0;
        start8 = 1'b0; op8 = 3'd0; opa8 = '0; opb8 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_dbz", 64'(dbz), 64'd0);
        rst = 1'b0;

        // MULT -2 * 3
        run32(3'd0, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0);
        check("mult_lat", 64'(lat), 64'd34);
        check("mult_busy_window", 64'(busy_err), 64'd0);
        check("mult_busy_done", 64'(busy), 64'd0);
        check("mult_res", result, 64'hFFFF_FFFF_FFFF_FFFA);
        check("mult_dbz", 64'(dbz), 64'd0);
        release32("mult");

        run32(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
        check("multu_res", result, 64'hFFFF_FFFE_0000_0001);
        release32("multu");

        run32(3'd2, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF);
        check("madd_res", result, 64'h0000_0001_0000_0000);
        release32("madd");

        run32(3'd5, 32'd1, 32'd1, 32'd0, 32'd0);
        check("msubu_res", result, 64'hFFFF_FFFF_FFFF_FFFF);
        release32("msubu");

        run32(3'd4, 32'd3, 32'd5, 32'd0, 32'd100);
        check("msub_res", result, 64'h0000_0000_0000_0055);
        release32("msub");

        run32(3'd6, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
        check("div_neg_res", result, 64'hFFFF_FFFF_FFFF_FFFD);
        check("div_neg_lat", 64'(lat), 64'd34);
        release32("div_neg");

        run32(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
        check("div_ovf_res", result, 64'h0000_0000_8000_0000);
        check("div_ovf_dbz", 64'(dbz), 64'd0);
        release32("div_ovf");

        run32(3'd7, 32'd100, 32'd7, 32'd0, 32'd0);
        check("divu_res", result, 64'h0000_0002_0000_000E);
        release32("divu");

        run32(3'd7, 32'd7, 32'd0, 32'd0, 32'd0);
        check("dbz_lat", 64'(lat), 64'd1);
        check("dbz_flag", 64'(dbz), 64'd1);
        check("dbz_res", result, 64'd0);
        release32("dbz");
        check("dbz_flag_clear", 64'(dbz), 64'd0);

        // Annul at cycle 10 of a MULT
        op = 3'd0; opa = 32'd6; opb = 32'd7; start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("annul_busy_c10", 64'(busy), 64'd1);
        annul = 1'b1; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        annul = 1'b0;
        check("annul_busy_c11", 64'(busy), 64'd0);
        seen_ready = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready) seen_ready++;
        end
        check("annul_no_ready", 64'(seen_ready), 64'd0);
        run32(3'd0, 32'd6, 32'hFFFF_FFF9, 32'd0, 32'd0);
        check("after_annul_res", result, 64'hFFFF_FFFF_FFFF_FFD6);
        check("after_annul_lat", 64'(lat), 64'd34);

        // Hold in DONE with operands changing
        opa = 32'h1234_5678; opb = 32'd0; op = 3'd7;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_ready", 64'(ready), 64'd1);
            check("hold_res", result, 64'hFFFF_FFFF_FFFF_FFD6);
        end
        release32("hold");

        // Reset mid-operation
        run32(3'd1, 32'd3, 32'd3, 32'd0, 32'd0);
        start = 1'b0;
        @(posedge clk);
        op = 3'd1; opa = 32'd9; opb = 32'd9; start = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ready", 64'(ready), 64'd0);

        // WIDTH=8 instance
        run8(3'd0, 8'hFE, 8'd3);
        check("w8_mult_lat", 64'(lat), 64'd10);
        check("w8_mult_res", 64'(result8), 64'h0000_0000_0000_FFFA);
        start8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("w8_idle_ready", 64'(ready8), 64'd0);
        run8(3'd6, 8'hF9, 8'd2);
        check("w8_div_res", 64'(result8), 64'h0000_0000_0000_FFFD);
        check("w8_div_busy", 64'(busy8), 64'd0);
        check("w8_div_dbz", 64'(dbz8), 64'd0);
        start8 = 1'b0;
        @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
